// File: rtl/median_feed_ctrl.sv
// Feed controller for a systolic median-sorting array: buffers samples,
// broadcasts one per insert slot and captures the middle cell's value.
module median_feed_ctrl #(
    parameter int R_WIDTH = 8,
    parameter int N       = 3,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               srst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [R_WIDTH-1:0] s_data,
    input  logic               flush,
    output logic [R_WIDTH-1:0] X,
    output logic               incre_en,
    output logic               phase,
    input  logic [R_WIDTH-1:0] med_in,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [R_WIDTH-1:0] m_data,
    output logic               underrun,
    output logic               drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FW = $clog2(N + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    logic [1:0]         state;
    logic               fcnt;
    logic [R_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count;
    logic [FW-1:0]      fill;
    logic [R_WIDTH-1:0] x_hold;

    logic fifo_empty;
    logic insert;
    logic push;
    logic pop;
    logic capture;
    logic clearing;

    assign fifo_empty = (count == '0);
    assign s_ready    = (count < CW'(DEPTH));
    assign clearing   = flush || (state == ST_FLUSH);
    assign insert     = (state == ST_RUN) && !phase && !flush;
    assign push       = s_valid && s_ready && !clearing;
    assign pop        = insert && !fifo_empty;
    assign capture    = insert && (fill == FW'(N));
    assign incre_en   = (state == ST_RUN);

    // The popped head reaches the array in the same cycle it leaves the FIFO.
    assign X = pop ? mem[rd_ptr] : x_hold;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            phase  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            phase <= ~phase;
            if (clearing) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state <= ST_IDLE;
            fcnt  <= 1'b0;
        end else if (flush) begin
            state <= ST_FLUSH;
            fcnt  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (phase && !fifo_empty) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: state <= ST_RUN;
                ST_FLUSH: begin
                    if (fcnt) begin
                        state <= ST_IDLE;
                    end
                    fcnt <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            x_hold   <= '0;
            fill     <= '0;
            underrun <= 1'b0;
        end else begin
            if (pop) begin
                x_hold <= mem[rd_ptr];
            end
            if (state != ST_RUN || flush) begin
                fill <= '0;
            end else if (insert && fill != FW'(N)) begin
                fill <= fill + FW'(1);
            end
            // An empty insert slot still advances the array with a repeat.
            if (flush) begin
                underrun <= 1'b0;
            end else if (insert && fifo_empty) begin
                underrun <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            drop    <= 1'b0;
        end else if (clearing) begin
            m_valid <= 1'b0;
            if (flush) begin
                drop <= 1'b0;
            end
        end else if (capture) begin
            m_valid <= 1'b1;
            m_data  <= med_in;
            if (m_valid && !m_ready) begin
                drop <= 1'b1;
            end
        end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_feed_ctrl.sv
// Scoreboard bench for median_feed_ctrl with a 3-cell median array model
// driving med_in from the samples broadcast on X.
module tb_median_feed_ctrl;

    logic       clk = 1'b0;
    logic       srst;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       flush;
    logic [7:0] X;
    logic       incre_en;
    logic       phase;
    logic [7:0] med_in;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       underrun;
    logic       drop;

    median_feed_ctrl #(.R_WIDTH(8), .N(3), .DEPTH(4)) dut (
        .clk(clk), .srst(srst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .flush(flush), .X(X), .incre_en(incre_en), .phase(phase),
        .med_in(med_in), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .underrun(underrun), .drop(drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_x[$];
    logic [7:0] exp_med[$];
    logic [7:0] win [3];
    bit saw_full;

    function automatic logic [7:0] median3(input logic [7:0] a, b, c);
        logic [7:0] lo, hi, m;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        m  = (hi < c) ? hi : c;
        return (lo > m) ? lo : m;
    endfunction

    always @(posedge clk) begin
        if (srst) begin
            win[0] <= '0;
            win[1] <= '0;
            win[2] <= '0;
        end else if (incre_en && !phase) begin
            win[2] <= win[1];
            win[1] <= win[0];
            win[0] <= X;
        end
    end
    assign med_in = median3(win[0], win[1], win[2]);

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!srst) begin
            if (incre_en && !phase && exp_x.size() > 0) begin
                check("x_slot", X, exp_x.pop_front());
            end
            if (m_valid && m_ready && exp_med.size() > 0) begin
                check("m_data", m_data, exp_med.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int t;
        s_valid = 1'b1;
        s_data  = d;
        t = 0;
        @(negedge clk);
        while (!s_ready && t < 50) begin
            saw_full = 1'b1;
            t++;
            @(negedge clk);
        end
        if (t >= 50) check("send_timeout", 1, 0);
        step();
        s_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_x.size() > 0 || exp_med.size() > 0) && t < 100) begin
            step();
            t++;
        end
        check("drain_timeout", t >= 100, 0);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_incre_c1", incre_en, 0);
        check("flush_mvalid_c1", m_valid, 0);
        check("flush_underrun", underrun, 0);
        check("flush_drop", drop, 0);
        step();
        check("flush_incre_c2", incre_en, 0);
        check("flush_mvalid_c2", m_valid, 0);
        check("flush_sready", s_ready, 1);
        step();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_sready"}, s_ready, 1);
        check({tag, "_incre"}, incre_en, 0);
        check({tag, "_x"}, X, 0);
        check({tag, "_mvalid"}, m_valid, 0);
        check({tag, "_mdata"}, m_data, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_drop"}, drop, 0);
        check({tag, "_phase"}, phase, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [7:0] s1 [4] = '{8'd10, 8'd30, 8'd20, 8'd50};
        logic [7:0] s2 [5] = '{8'd10, 8'd30, 8'd20, 8'd50, 8'd40};
        srst = 1'b1; s_valid = 1'b0; s_data = '0;
        flush = 1'b0; m_ready = 1'b1; saw_full = 1'b0;
        repeat (3) step();
        check_reset("rst");
        srst = 1'b0;
        check("phase_after_rst", phase, 0);

        // streaming window, then underrun once the stream stops
        exp_x = '{8'd10, 8'd30, 8'd20, 8'd50, 8'd50};
        exp_med = '{8'd20, 8'd30};
        foreach (s1[i]) send(s1[i]);
        wait_drain();
        check("underrun_set", underrun, 1);
        repeat (5) step();
        check("underrun_sticky", underrun, 1);
        do_flush();

        // backpressure on the median output
        m_ready = 1'b0;
        exp_x = '{8'd10, 8'd30, 8'd20, 8'd50, 8'd40, 8'd40};
        exp_med = '{8'd40, 8'd40};
        foreach (s2[i]) send(s2[i]);
        t = 0;
        while (!m_valid && t < 50) begin
            step();
            t++;
        end
        check("first_med_timeout", t >= 50, 0);
        for (int i = 0; i < 4; i++) begin
            check("mvalid_held", m_valid, 1);
            step();
        end
        check("drop_set", drop, 1);
        m_ready = 1'b1;
        wait_drain();
        check("drop_sticky", drop, 1);
        do_flush();

        // FIFO fills while pushing faster than the array consumes
        saw_full = 1'b0;
        exp_x = '{1, 2, 3, 4, 5, 6, 7, 8};
        exp_med = '{2, 3, 4, 5, 6, 7};
        for (int i = 1; i <= 8; i++) send(8'(i));
        check("fifo_full_seen", saw_full, 1);
        wait_drain();
        do_flush();

        // synchronous reset in the middle of a run
        for (int i = 0; i < 4; i++) send(8'(100 + i));
        step();
        check("run_before_rst", incre_en, 1);
        exp_x.delete();
        exp_med.delete();
        srst = 1'b1;
        step();
        check_reset("midrst");
        srst = 1'b0;
        check("phase_after_midrst", phase, 0);
        repeat (4) step();
        check("idle_after_midrst", incre_en, 0);

        check("x_queue_empty", exp_x.size(), 0);
        check("med_queue_empty", exp_med.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
